// File: rtl/mult_div_unit_if.sv
// Control-unit <-> multiply/divide unit bus.
//   master (control unit): drives CtoM, Op, A, B; observes MtoC, Busy, DivZero, High, Low
//   slave  (mult_div_unit): the reverse
//   CtoM    start request, sampled only while the unit is idle
//   Op      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   A, B    multiplicand/dividend, multiplier/divisor
//   MtoC    one-cycle completion pulse
//   Busy    operation in progress
//   DivZero last completed op was a divide by zero
//   High    product upper half / remainder
//   Low     product lower half / quotient
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             CtoM;
  logic [1:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             MtoC;
  logic             Busy;
  logic             DivZero;
  logic [WIDTH-1:0] High;
  logic [WIDTH-1:0] Low;

  modport master (
    output CtoM, Op, A, B,
    input  MtoC, Busy, DivZero, High, Low
  );

  modport slave (
    input  CtoM, Op, A, B,
    output MtoC, Busy, DivZero, High, Low
  );
endinterface

// File: rtl/mult_div_unit.sv
// Sequential radix-2 multiply/divide unit for the HI/LO path.
// Signed ops run on magnitudes and are sign-corrected in a single FIX cycle.
// Latency from the capture edge to valid High/Low is WIDTH+1 cycles.
//   Clock  system clock, rising edge
//   Reset  asynchronous, active-low
//   bus    mult_div_unit_if slave port (CtoM/Op/A/B in; MtoC/Busy/DivZero/High/Low out)
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic            Clock,
  input logic            Reset,
  mult_div_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic             is_div_q;
  logic             res_neg_q;
  logic             a_neg_q;
  logic             b_zero_q;
  logic [WIDTH-1:0] opnd_q;   // multiplicand |A| or divisor |B|
  logic [WIDTH-1:0] hi_q;     // product upper half / partial remainder
  logic [WIDTH-1:0] lo_q;     // multiplier bits / dividend bits shifting into quotient
  logic [WIDTH-1:0] a_raw_q;

  logic [WIDTH-1:0] high_q, low_q;
  logic             mtoc_q, dz_q;

  logic             is_signed;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             last_iter;
  logic [WIDTH:0]   add_sum, part_rem, trial;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.CtoM) state_d = CALC;
      CALC:    if (last_iter) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand magnitudes at capture
  always_comb begin
    is_signed = ~bus.Op[0];
    mag_a = (is_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    mag_b = (is_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;
  end

  // One iteration. Multiply and divide share hi_q/lo_q: multiply shifts right
  // (carry enters hi, product bit drops into lo), divide shifts left
  // (dividend bit leaves lo into the partial remainder, quotient bit enters lo).
  always_comb begin
    add_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    part_rem = {hi_q, lo_q[WIDTH-1]};
    trial    = part_rem - {1'b0, opnd_q};
    if (is_div_q) begin
      if (!trial[WIDTH]) begin
        hi_nxt = trial[WIDTH-1:0];
        lo_nxt = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = part_rem[WIDTH-1:0];
        lo_nxt = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_nxt = add_sum[WIDTH:1];
      lo_nxt = {add_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Sign correction applied in FIX
  always_comb begin
    prod_raw = {hi_q, lo_q};
    prod_fix = res_neg_q ? -prod_raw : prod_raw;
    quo_fix  = res_neg_q ? -lo_q : lo_q;
    rem_fix  = a_neg_q ? -hi_q : hi_q;
  end

  // Datapath and result registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      res_neg_q <= 1'b0;
      a_neg_q   <= 1'b0;
      b_zero_q  <= 1'b0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      a_raw_q   <= '0;
      high_q    <= '0;
      low_q     <= '0;
      mtoc_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      mtoc_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.CtoM) begin
            is_div_q  <= bus.Op[1];
            res_neg_q <= is_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            a_neg_q   <= is_signed & bus.A[WIDTH-1];
            b_zero_q  <= (bus.B == '0);
            a_raw_q   <= bus.A;
            opnd_q    <= bus.Op[1] ? mag_b : mag_a;
            lo_q      <= bus.Op[1] ? mag_a : mag_b;
            hi_q      <= '0;
            cnt_q     <= '0;
          end
        end
        CALC: begin
          hi_q  <= hi_nxt;
          lo_q  <= lo_nxt;
          cnt_q <= cnt_q + CW'(1);
        end
        FIX: begin
          mtoc_q <= 1'b1;
          dz_q   <= is_div_q & b_zero_q;
          if (!is_div_q) begin
            {high_q, low_q} <= prod_fix;
          end else if (b_zero_q) begin
            high_q <= a_raw_q;
            low_q  <= '1;
          end else begin
            high_q <= rem_fix;
            low_q  <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.MtoC    = mtoc_q;
  assign bus.Busy    = (state_q != IDLE);
  assign bus.DivZero = dz_q;
  assign bus.High    = high_q;
  assign bus.Low     = low_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit at WIDTH = 32 and WIDTH = 8.
// A transaction-level model computes each result with plain integer
// arithmetic and tracks when it must appear; one compare process checks
// every output of both units each cycle and also services literal checks
// posted by the stimulus process.
module tb_mult_div_unit;

  typedef struct packed {
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic clk = 1'b0;
  logic rst32 = 1'b1;
  logic rst8  = 1'b1;

  mult_div_unit_if #(.WIDTH(32)) bus32 ();
  mult_div_unit_if #(.WIDTH(8))  bus8 ();

  mult_div_unit #(.WIDTH(32)) dut32 (
    .Clock (clk),
    .Reset (rst32),
    .bus   (bus32.slave)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .Clock (clk),
    .Reset (rst8),
    .bus   (bus8.slave)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference result from arithmetic on w-bit operands.
  function automatic res_t model(input int w, input logic [1:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
    res_t r;
    longint unsigned mask, ua, ub, up, ur;
    longint sa, sb, q, rm;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'b0, a} & mask;
    ub = {32'b0, b} & mask;
    sa = a[w-1] ? (longint'(ua) - (longint'(1) << w)) : longint'(ua);
    sb = b[w-1] ? (longint'(ub) - (longint'(1) << w)) : longint'(ub);
    r.dz = 1'b0;
    if (!op[1]) begin
      if (!op[0]) up = $unsigned(sa * sb);
      else        up = ua * ub;
      r.lo = 32'(up & mask);
      r.hi = 32'((up >> w) & mask);
    end else if (ub == 0) begin
      r.dz = 1'b1;
      r.lo = 32'(mask);
      r.hi = 32'(ua);
    end else begin
      if (!op[0]) begin
        q  = sa / sb;
        rm = sa % sb;
        up = $unsigned(q);
        ur = $unsigned(rm);
      end else begin
        up = ua / ub;
        ur = ua % ub;
      end
      r.lo = 32'(up & mask);
      r.hi = 32'(ur & mask);
    end
    return r;
  endfunction

  // Timing model: accept when idle, result and pulse WIDTH+1 edges later.
  logic m32_busy = 1'b0, m32_mtoc = 1'b0;
  int   m32_cnt = 0;
  res_t m32_pend = '0, m32_res = '0;

  always @(posedge clk or negedge rst32) begin
    if (!rst32) begin
      m32_busy <= 1'b0;
      m32_mtoc <= 1'b0;
      m32_cnt  <= 0;
      m32_res  <= '0;
    end else begin
      m32_mtoc <= 1'b0;
      if (m32_busy) begin
        if (m32_cnt == 1) begin
          m32_busy <= 1'b0;
          m32_mtoc <= 1'b1;
          m32_res  <= m32_pend;
        end
        m32_cnt <= m32_cnt - 1;
      end else if (bus32.CtoM) begin
        m32_busy <= 1'b1;
        m32_cnt  <= 33;
        m32_pend <= model(32, bus32.Op, bus32.A, bus32.B);
      end
    end
  end

  logic m8_busy = 1'b0, m8_mtoc = 1'b0;
  int   m8_cnt = 0;
  res_t m8_pend = '0, m8_res = '0;

  always @(posedge clk or negedge rst8) begin
    if (!rst8) begin
      m8_busy <= 1'b0;
      m8_mtoc <= 1'b0;
      m8_cnt  <= 0;
      m8_res  <= '0;
    end else begin
      m8_mtoc <= 1'b0;
      if (m8_busy) begin
        if (m8_cnt == 1) begin
          m8_busy <= 1'b0;
          m8_mtoc <= 1'b1;
          m8_res  <= m8_pend;
        end
        m8_cnt <= m8_cnt - 1;
      end else if (bus8.CtoM) begin
        m8_busy <= 1'b1;
        m8_cnt  <= 9;
        m8_pend <= model(8, bus8.Op, {24'b0, bus8.A}, {24'b0, bus8.B});
      end
    end
  end

  // Literal-check request posted by the stimulus process
  int          lit_seq = 0;
  int          lit_seen = 0;
  int          lit_unit = 0;
  string       lit_name = "";
  logic        lit_vals = 1'b0;
  logic [31:0] lit_hi = '0, lit_lo = '0;
  logic        lit_dz = 1'b0;
  int          lit_lat = 0, lit_exp_lat = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin : cmp
    logic [31:0] act_hi, act_lo;
    logic        act_dz;
    chk("busy32",  32'(bus32.Busy),    32'(m32_busy));
    chk("mtoc32",  32'(bus32.MtoC),    32'(m32_mtoc));
    chk("dz32",    32'(bus32.DivZero), 32'(m32_res.dz));
    chk("high32",  bus32.High,         m32_res.hi);
    chk("low32",   bus32.Low,          m32_res.lo);
    chk("busy8",   32'(bus8.Busy),     32'(m8_busy));
    chk("mtoc8",   32'(bus8.MtoC),     32'(m8_mtoc));
    chk("dz8",     32'(bus8.DivZero),  32'(m8_res.dz));
    chk("high8",   {24'b0, bus8.High}, m8_res.hi);
    chk("low8",    {24'b0, bus8.Low},  m8_res.lo);
    if (lit_seq != lit_seen) begin
      lit_seen <= lit_seq;
      if (lit_unit == 0) begin
        act_hi = bus32.High;
        act_lo = bus32.Low;
        act_dz = bus32.DivZero;
      end else begin
        act_hi = {24'b0, bus8.High};
        act_lo = {24'b0, bus8.Low};
        act_dz = bus8.DivZero;
      end
      if (lit_vals) begin
        chk({lit_name, ".high"}, act_hi, lit_hi);
        chk({lit_name, ".low"},  act_lo, lit_lo);
        chk({lit_name, ".dz"},   32'(act_dz), 32'(lit_dz));
      end
      if (lit_exp_lat >= 0) chk({lit_name, ".latency"}, 32'(lit_lat), 32'(lit_exp_lat));
    end
  end

  task automatic post(input int u, input string name, input logic vals,
                      input logic [31:0] hi, input logic [31:0] lo, input logic dz,
                      input int lat, input int exp_lat);
    lit_unit    = u;
    lit_name    = name;
    lit_vals    = vals;
    lit_hi      = hi;
    lit_lo      = lo;
    lit_dz      = dz;
    lit_lat     = lat;
    lit_exp_lat = exp_lat;
    lit_seq++;
    @(negedge clk);
    #1;
  endtask

  // Drive a request for one edge, then scramble operands to show they were latched.
  task automatic start(input int u, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (u == 0) begin
      bus32.CtoM = 1'b1; bus32.Op = op; bus32.A = a; bus32.B = b;
    end else begin
      bus8.CtoM = 1'b1; bus8.Op = op; bus8.A = a[7:0]; bus8.B = b[7:0];
    end
    @(posedge clk);
    #2;
    if (u == 0) begin
      bus32.CtoM = 1'b0; bus32.Op = 2'($urandom); bus32.A = $urandom; bus32.B = $urandom;
    end else begin
      bus8.CtoM = 1'b0; bus8.Op = 2'($urandom); bus8.A = 8'($urandom); bus8.B = 8'($urandom);
    end
  endtask

  task automatic wait_done(input int u, output int lat);
    logic seen;
    seen = 1'b0;
    lat = -1;
    for (int n = 1; n <= 200 && !seen; n++) begin
      @(posedge clk);
      #2;
      if ((u == 0) ? bus32.MtoC : bus8.MtoC) begin
        seen = 1'b1;
        lat = n;
      end
    end
  endtask

  task automatic do_op(input int u, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string name, input logic vals,
                       input logic [31:0] hi, input logic [31:0] lo, input logic dz);
    int lat;
    start(u, op, a, b);
    wait_done(u, lat);
    post(u, name, vals, hi, lo, dz, lat, (u == 0) ? 33 : 9);
  endtask

  function automatic logic [31:0] pick(input int w);
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return mask;
      3:       return (w == 32) ? 32'h8000_0000 : 32'h0000_0080;
      4:       return mask >> 1;
      default: return $urandom & mask;
    endcase
  endfunction

  initial begin : stim
    int lat;
    bus32.CtoM = 1'b0; bus32.Op = '0; bus32.A = '0; bus32.B = '0;
    bus8.CtoM  = 1'b0; bus8.Op  = '0; bus8.A  = '0; bus8.B  = '0;
    #1;
    rst32 = 1'b0;
    rst8  = 1'b0;
    #22;
    rst32 = 1'b1;
    rst8  = 1'b1;
    @(posedge clk);
    #2;
    post(0, "reset32", 1'b1, 32'h0, 32'h0, 1'b0, 0, -1);
    post(1, "reset8",  1'b1, 32'h0, 32'h0, 1'b0, 0, -1);

    do_op(0, 2'b00, 32'hFFFF_FFFD, 32'd7,        "mult_m3x7",   1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    do_op(0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max",  1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    do_op(0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult_m1m1",  1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0);
    do_op(0, 2'b10, 32'hFFFF_FFF9, 32'd2,        "div_m7by2",   1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    do_op(0, 2'b11, 32'd100,       32'd7,        "divu_100by7", 1'b1, 32'd2,         32'd14,        1'b0);
    do_op(0, 2'b11, 32'd100,       32'd0,        "divu_by0",    1'b1, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
    do_op(0, 2'b00, 32'd2,         32'd3,        "mult_2x3",    1'b1, 32'd0,         32'd6,         1'b0);
    do_op(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1", 1'b1, 32'h0000_0000, 32'h8000_0000, 1'b0);

    // CtoM while busy is ignored
    start(0, 2'b11, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #2;
    bus32.CtoM = 1'b1; bus32.Op = 2'b00; bus32.A = 32'd5; bus32.B = 32'd9;
    @(posedge clk);
    #2;
    bus32.CtoM = 1'b0;
    wait_done(0, lat);
    post(0, "ignored_ctom", 1'b1, 32'd2, 32'd14, 1'b0, lat, 28);

    // Reset mid-operation: no completion, outputs cleared, next request taken at once
    start(0, 2'b00, 32'd12345, 32'd678);
    repeat (10) @(posedge clk);
    #2;
    rst32 = 1'b0;
    #4;
    rst32 = 1'b1;
    start(0, 2'b01, 32'd3, 32'd5);
    post(0, "reset_clears", 1'b1, 32'd0, 32'd0, 1'b0, 0, -1);
    wait_done(0, lat);
    post(0, "after_reset", 1'b1, 32'd0, 32'd15, 1'b0, lat, 33);

    do_op(1, 2'b00, 32'h80, 32'h80, "w8_mult_min", 1'b1, 32'h40, 32'h00, 1'b0);
    do_op(1, 2'b11, 32'h64, 32'h00, "w8_divu_by0", 1'b1, 32'h64, 32'hFF, 1'b1);

    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 30; i++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #2;
        end
        do_op(u, 2'($urandom), pick(u == 0 ? 32 : 8), pick(u == 0 ? 32 : 8),
              (u == 0) ? "rand32" : "rand8", 1'b0, 32'h0, 32'h0, 1'b0);
      end
    end

    repeat (3) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
